slide_data_player: RTL and testbench
====================================

SLIDE_DATA_PLAYER -- requirements
Module: slide_data_player

Interface
REQ-001 Parameter DW, 7, sample width in bits, matching the Slide_Data lane width.
REQ-002 Parameter LEN_A, 451, entries in banks 0..2 and the playback length in beats.
REQ-003 Parameter LEN_B, 449, entries in bank 3.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  load strobe; one sample is written per cycle while high.
REQ-007 wr_data  input  DW  load sample.
REQ-008 start  input  1  playback request, sampled only in LOADED.
REQ-009 out_ready  input  1  consumer ready.
REQ-010 out_valid  output  1  lane data valid.
REQ-011 Slide_Data_0 / _1 / _2 / _3  output  DW each  parallel lane samples.
REQ-012 lane3_valid  output  1  Slide_Data_3 carries a real sample.
REQ-013 loaded  output  1  all 2*LEN_A+LEN_A+LEN_B (1802) samples written.
REQ-014 busy  output  1  playback in progress.
REQ-015 done  output  1  one-cycle pulse after the final beat.
REQ-016 overflow  output  1  sticky flag: a write was attempted when full.

Function
REQ-017 Storage SHALL be four banks: bank0 [0..450], bank1 [0..450], bank2 [0..450], bank3 [0..448]; the memory itself is not reset.
REQ-018 Load SHALL use a write pointer wp (0..1801) with bank = wp/451 and offset = wp mod 451; wp increments on each accepted write.
REQ-019 A write SHALL be accepted only in IDLE with wr_en=1.
REQ-020 The write with wp=1801 SHALL move the FSM to LOADED on the next edge.
REQ-021 wr_en in any state other than IDLE SHALL be ignored and SHALL set overflow.
REQ-022 FSM states: IDLE(load) -> LOADED -> PLAY -> DONE -> LOADED; these are the only transitions apart from reset.
REQ-023 In LOADED, start=1 SHALL enter PLAY with read index ri=0.
REQ-024 out_valid SHALL rise on the cycle after start is sampled.
REQ-025 Start latency is therefore 1 cycle.
REQ-026 In PLAY, the outputs SHALL present bank0[ri], bank1[ri], bank2[ri], bank3[ri] from registers.
REQ-027 The lane outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 A beat completes when out_valid and out_ready are both 1; ri SHALL then advance and the next beat's data SHALL appear the following cycle.
REQ-029 Full throughput SHALL be one beat per cycle when out_ready is held high.
REQ-030 For ri=449 and ri=450, lane3_valid SHALL be 0 and Slide_Data_3 SHALL be 0.
REQ-031 For ri<449, lane3_valid SHALL equal out_valid.
REQ-032 When the beat at ri=450 completes, the FSM SHALL enter DONE.
REQ-033 In DONE, out_valid SHALL drop, done SHALL be 1 for that single cycle, and the FSM SHALL return to LOADED.
REQ-034 Replay SHALL be allowed on a new start without reloading.
REQ-035 start in IDLE, PLAY or DONE SHALL be ignored.
REQ-036 loaded SHALL be 1 in LOADED, PLAY and DONE.
REQ-037 busy SHALL be 1 only in PLAY.
REQ-038 Exactly 451 beats SHALL be produced per playback.

Reset
REQ-039 While rst=1 at a clock edge, the FSM SHALL go to IDLE, wp=0 and ri=0.
REQ-040 Under reset, out_valid, lane3_valid, loaded, busy, done and overflow SHALL all be 0, and Slide_Data_0..3 SHALL be 0.
REQ-041 Reset during PLAY SHALL abort playback with no further beats and no done pulse; a full reload is then required.
REQ-042 Bank contents SHALL be retained across reset but treated as invalid.

Verification
REQ-043 Load ramp sample k = k mod 128 for 1802 cycles, then start with out_ready=1 -> 451 consecutive beats, beat n = {n, (n+451)%128, (n+902)%128, (n+1353)%128}, and done pulses once, 1 cycle after beat 450.
REQ-044 Random out_ready (50%) -> identical beat sequence, no dropped or duplicated beat, and data held stable while stalled.
REQ-045 Beats 449 and 450 -> lane3_valid=0 and Slide_Data_3=0; all other beats -> lane3_valid=1.
REQ-046 Write sample 1803 after load -> write ignored, overflow=1 and sticky, playback data unchanged.
REQ-047 Assert rst at beat 200 -> next cycle out_valid=0, busy=0, loaded=0, no done; start is then ignored until 1802 new writes complete.
REQ-048 Second start after done -> same 451 beats replayed; start asserted during PLAY -> no effect.

Source files
------------

// File: rtl/slide_data_player.sv
// rtl/slide_data_player.sv - four-bank sample store with lane-parallel valid/ready playback
module slide_data_player #(
    parameter int DW    = 7,
    parameter int LEN_A = 451,
    parameter int LEN_B = 449
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] Slide_Data_0,
    output logic [DW-1:0] Slide_Data_1,
    output logic [DW-1:0] Slide_Data_2,
    output logic [DW-1:0] Slide_Data_3,
    output logic          lane3_valid,
    output logic          loaded,
    output logic          busy,
    output logic          done,
    output logic          overflow
);
    localparam int AW = $clog2(LEN_A);
    localparam logic [AW-1:0] LAST_A = AW'(LEN_A - 1);
    localparam logic [AW-1:0] LAST_B = AW'(LEN_B - 1);
    localparam logic [AW-1:0] LANE3_END = AW'(LEN_B);

    typedef enum logic [1:0] {S_IDLE, S_LOADED, S_PLAY, S_DONE} state_t;
    state_t state_q, state_d;

    logic [1:0]    bank_q;
    logic [AW-1:0] off_q;
    logic [AW-1:0] ri_q;
    logic          ovf_q;
    logic [DW-1:0] d0_q, d1_q, d2_q, d3_q;

    logic [DW-1:0] mem0 [LEN_A];
    logic [DW-1:0] mem1 [LEN_A];
    logic [DW-1:0] mem2 [LEN_A];
    logic [DW-1:0] mem3 [LEN_B];

    logic          wr_acc, load_last, beat, last_beat, rd_en;
    logic [AW-1:0] rd_idx;

    assign wr_acc    = (state_q == S_IDLE) && wr_en;
    assign load_last = wr_acc && (bank_q == 2'd3) && (off_q == LAST_B);
    assign beat      = (state_q == S_PLAY) && out_ready;
    assign last_beat = beat && (ri_q == LAST_A);
    assign rd_en     = ((state_q == S_LOADED) && start) || (beat && !last_beat);
    assign rd_idx    = (state_q == S_LOADED) ? '0 : ri_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load_last) state_d = S_LOADED;
            S_LOADED: if (start)     state_d = S_PLAY;
            S_PLAY:   if (last_beat) state_d = S_DONE;
            S_DONE:   state_d = S_LOADED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid   = (state_q == S_PLAY);
        busy        = (state_q == S_PLAY);
        done        = (state_q == S_DONE);
        loaded      = (state_q != S_IDLE);
        lane3_valid = (state_q == S_PLAY) && (ri_q < LANE3_END);
    end

    // Banks are deliberately unreset; the FSM alone decides whether they hold a valid load.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            case (bank_q)
                2'd0:    mem0[off_q] <= wr_data;
                2'd1:    mem1[off_q] <= wr_data;
                2'd2:    mem2[off_q] <= wr_data;
                default: mem3[off_q] <= wr_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
            off_q  <= '0;
            ri_q   <= '0;
            ovf_q  <= 1'b0;
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
        end else begin
            if (wr_acc) begin
                if (off_q == LAST_A) begin
                    off_q  <= '0;
                    bank_q <= bank_q + 1'b1;
                end else begin
                    off_q <= off_q + 1'b1;
                end
            end
            if (wr_en && (state_q != S_IDLE)) ovf_q <= 1'b1;
            if (state_q == S_LOADED && start) ri_q <= '0;
            else if (last_beat)               ri_q <= '0;
            else if (beat)                    ri_q <= ri_q + 1'b1;
            // Lane registers only move on start or a completed beat, so stalls hold them.
            if (rd_en) begin
                d0_q <= mem0[rd_idx];
                d1_q <= mem1[rd_idx];
                d2_q <= mem2[rd_idx];
                d3_q <= (rd_idx < LANE3_END) ? mem3[rd_idx] : '0;
            end
        end
    end

    assign overflow     = ovf_q;
    assign Slide_Data_0 = d0_q;
    assign Slide_Data_1 = d1_q;
    assign Slide_Data_2 = d2_q;
    assign Slide_Data_3 = d3_q;
endmodule

// File: tb/tb_slide_data_player.sv
// tb/tb_slide_data_player.sv - scoreboard bench for slide_data_player load/playback/reset
module tb_slide_data_player;
    localparam int DW = 7;
    localparam int LEN_A = 451;
    localparam int TOTAL = 1802;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, out_ready;
    logic [DW-1:0] wr_data;
    logic          out_valid, lane3_valid, loaded, busy, done, overflow;
    logic [DW-1:0] sd0, sd1, sd2, sd3;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [4*DW:0] exp_q [$];

    slide_data_player #(.DW(DW), .LEN_A(LEN_A), .LEN_B(449)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .out_ready(out_ready), .out_valid(out_valid),
        .Slide_Data_0(sd0), .Slide_Data_1(sd1), .Slide_Data_2(sd2), .Slide_Data_3(sd3),
        .lane3_valid(lane3_valid), .loaded(loaded), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] samp(input int k, input int seed);
        return 7'((k + seed) % 128);
    endfunction

    function automatic logic [4*DW:0] exp_beat(input int n, input int seed);
        logic          l3v;
        logic [DW-1:0] s3;
        l3v = (n < 449);
        s3  = l3v ? samp(n + 3 * LEN_A, seed) : '0;
        return {l3v, s3, samp(n + 2 * LEN_A, seed), samp(n + LEN_A, seed), samp(n, seed)};
    endfunction

    // Monitor: pops on every completed beat, checks stall stability and counts done pulses.
    initial begin
        logic          prev_stall;
        logic [4*DW:0] prev_data, act, exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                act = {lane3_valid, sd3, sd2, sd1, sd0};
                if (prev_stall && out_valid)
                    check("stall_hold", 32'(act), 32'(prev_data));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(act), 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat", 32'(act), 32'(exp));
                    end
                end
                if (done) done_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_data  = act;
            end
        end
    end

    task automatic load(input int seed);
        for (int k = 0; k < TOTAL; k++) begin
            wr_en   = 1'b1;
            wr_data = samp(k, seed);
            start   = (k == 1000);
            if (k == TOTAL - 1) begin
                check("loaded_before_last", 32'(loaded), 0);
                check("start_ignored_idle", 32'(out_valid), 0);
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        start = 1'b0;
        check("loaded_after_load", 32'(loaded), 1);
        check("busy_after_load", 32'(busy), 0);
    endtask

    task automatic play(input int seed, input bit rnd, input bit poke);
        int cyc;
        for (int n = 0; n < LEN_A; n++) exp_q.push_back(exp_beat(n, seed));
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_rise", 32'(out_valid), 1);
        check("busy_play", 32'(busy), 1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (cyc == 100);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 5000) check("play_timeout", 32'(exp_q.size()), 0);
        check("done_pulse", 32'(done), 1);
        check("valid_drop", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("done_single", 32'(done), 0);
        check("loaded_after_done", 32'(loaded), 1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'({out_valid, lane3_valid, loaded, busy, done, overflow}), 0);
        check("rst_data", 32'({sd3, sd2, sd1, sd0}), 0);
        rst = 1'b0;

        load(0);
        check("no_overflow", 32'(overflow), 0);
        wr_en = 1'b1; wr_data = 7'h55;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("overflow_set", 32'(overflow), 1);

        play(0, 1'b0, 1'b0);
        check("done_count_1", done_cnt, 1);
        play(0, 1'b1, 1'b1);
        check("done_count_2", done_cnt, 2);
        check("overflow_sticky", 32'(overflow), 1);

        for (int n = 0; n < LEN_A; n++) exp_q.push_back(exp_beat(n, 0));
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 1000 && exp_q.size() > LEN_A - 200; c++) begin
            @(posedge clk); #1;
        end
        check("beats_before_rst", 32'(exp_q.size()), LEN_A - 200);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_abort", 32'({out_valid, busy, loaded, done, overflow}), 0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("start_ignored_after_rst", 32'({out_valid, loaded}), 0);
        check("no_done_after_rst", done_cnt, 2);

        load(17);
        play(17, 1'b1, 1'b0);
        check("done_count_3", done_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
